// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch and load/store requester ports, the
// shared response data, and the single-outstanding memory port.
// The slave modport is the arbiter's view. The master modport is the
// surrounding system, which drives requests and memory responses.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [BE_W-1:0]   ls_be;
  logic              ls_gnt;
  logic              ls_rvalid;

  logic [DATA_W-1:0] rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    output ls_gnt, ls_rvalid,
    output rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    input  ls_gnt, ls_rvalid,
    input  rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch, load/store) arbiter in front
// of a single memory port. It keeps at most one transaction outstanding.
// Optional feature: define ARB_ROUND_ROBIN_EN to break ties round-robin
// against the last owner. When it is undefined, load/store always wins a tie.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction; a pending request is granted combinationally
// ISSUE | mem_req held with latched fields until mem_gnt
// RESP  | waiting for mem_rvalid; response forwarded to the owner
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  mem_arbiter_if.slave bus,
  output logic        busy
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q;          // 0 = fetch, 1 = load/store
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] rdata_q;

  logic grant_if;
  logic grant_ls;
  logic resp_fire;
  logic ls_wins_tie;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_q;                  // 0 = fetch, 1 = load/store

  // A tie goes to whichever requester did not own the previous grant.
  assign ls_wins_tie = ~last_owner_q;

  // Remember the owner of every grant, including grants that were not ties.
  always_ff @(posedge clk) begin
    if (rst)
      last_owner_q <= 1'b0;
    else if (grant_if || grant_ls)
      last_owner_q <= grant_ls;
  end
`else
  assign ls_wins_tie = 1'b1;
`endif

  // Mask the response while in reset, so that an aborted transaction
  // cannot leak a response.
  assign resp_fire = !rst && (state_q == RESP) && bus.mem_rvalid;

  // Compute the grant decision and the next state. Grants appear only in
  // IDLE, and at most one of them is asserted.
  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_ls = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst) begin
          if (bus.if_req && bus.ls_req) begin
            if (ls_wins_tie) grant_ls = 1'b1;
            else             grant_if = 1'b1;
          end else if (bus.ls_req) begin
            grant_ls = 1'b1;
          end else if (bus.if_req) begin
            grant_if = 1'b1;
          end
        end
        if (grant_if || grant_ls) state_d = ISSUE;
      end
      ISSUE: begin
        // Any mem_rvalid seen here belongs to no request of ours.
        if (bus.mem_gnt) state_d = RESP;
      end
      RESP: begin
        if (bus.mem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register. Reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Latch the winner's request fields and its identity at grant time.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (grant_ls) begin
      owner_q <= 1'b1;
      we_q    <= bus.ls_we;
      addr_q  <= bus.ls_addr;
      wdata_q <= bus.ls_wdata;
      be_q    <= bus.ls_be;
    end else if (grant_if) begin
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= bus.if_addr;
      wdata_q <= '0;
      be_q    <= '1;
    end
  end

  // Keep the last response word so that rdata is stable between responses.
  always_ff @(posedge clk) begin
    if (rst)            rdata_q <= '0;
    else if (resp_fire) rdata_q <= bus.mem_rdata;
  end

  assign bus.if_gnt    = grant_if;
  assign bus.ls_gnt    = grant_ls;
  assign bus.if_rvalid = resp_fire && !owner_q;
  assign bus.ls_rvalid = resp_fire &&  owner_q;
  assign bus.rdata     = resp_fire ? bus.mem_rdata : rdata_q;

  assign bus.mem_req   = !rst && (state_q == ISSUE);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;

  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change 1 time unit after the
// rising edge and outputs are sampled on the falling edge. Expected
// responses go into a queue when the memory response is driven. A monitor
// pops the queue whenever the DUT raises an rvalid.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct {
    logic              ls;
    logic [DATA_W-1:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  resp_t exp_q[$];

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Check every response against the queue, and check the grant invariants.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("gnt_exclusive", 64'(bus.if_gnt && bus.ls_gnt), 64'd0);
      chk("gnt_when_busy", 64'((bus.if_gnt || bus.ls_gnt) && busy), 64'd0);
      if (bus.if_rvalid || bus.ls_rvalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rvalid", 64'd1, 64'd0);
        end else begin
          resp_t e;
          e = exp_q.pop_front();
          chk("sb_owner_ls", 64'(bus.ls_rvalid), 64'(e.ls));
          chk("sb_owner_if", 64'(bus.if_rvalid), 64'(!e.ls));
          chk("sb_rdata", 64'(bus.rdata), 64'(e.data));
        end
      end
    end
  end

  initial begin
    logic exp_ls;
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0; bus.ls_be = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

    // Reset values. A request is held during reset and must not be granted.
    cyc(); cyc();
    bus.if_req = 1'b1; bus.ls_req = 1'b1;
    @(negedge clk);
    chk("rst_if_gnt", 64'(bus.if_gnt), 64'd0);
    chk("rst_ls_gnt", 64'(bus.ls_gnt), 64'd0);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_mem_be", 64'(bus.mem_be), 64'd0);
    chk("rst_rdata", 64'(bus.rdata), 64'd0);
    cyc();
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    rst = 1'b0;
    mon_en = 1'b1;

    // Lone fetch at minimum latency.
    cyc();
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    @(negedge clk);
    chk("f_if_gnt_c0", 64'(bus.if_gnt), 64'd1);
    chk("f_mem_req_c0", 64'(bus.mem_req), 64'd0);
    cyc();
    bus.if_req = 1'b0; bus.if_addr = 32'hFFFF; bus.mem_gnt = 1'b1;
    @(negedge clk);
    chk("f_mem_req_c1", 64'(bus.mem_req), 64'd1);
    chk("f_mem_addr", 64'(bus.mem_addr), 64'h100);
    chk("f_mem_we", 64'(bus.mem_we), 64'd0);
    chk("f_mem_be", 64'(bus.mem_be), 64'hF);
    chk("f_busy", 64'(busy), 64'd1);
    cyc();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    exp_q.push_back('{ls: 1'b0, data: 32'hDEADBEEF});
    @(negedge clk);
    chk("f_mem_req_c2", 64'(bus.mem_req), 64'd0);
    chk("f_if_rvalid_c2", 64'(bus.if_rvalid), 64'd1);
    chk("f_rdata_c2", 64'(bus.rdata), 64'hDEADBEEF);
    cyc();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("f_idle", 64'(busy), 64'd0);

    // Store with mem_gnt stalled for 3 cycles. Inputs are scrambled after the grant.
    cyc();
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h2000;
    bus.ls_wdata = 32'h12345678; bus.ls_be = 4'b0011;
    @(negedge clk);
    chk("s_ls_gnt", 64'(bus.ls_gnt), 64'd1);
    chk("s_if_gnt", 64'(bus.if_gnt), 64'd0);
    cyc();
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = 32'h9; bus.ls_wdata = 32'h9; bus.ls_be = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.mem_gnt = 1'b1;
      @(negedge clk);
      chk("s_mem_req", 64'(bus.mem_req), 64'd1);
      chk("s_mem_we", 64'(bus.mem_we), 64'd1);
      chk("s_mem_addr", 64'(bus.mem_addr), 64'h2000);
      chk("s_mem_wdata", 64'(bus.mem_wdata), 64'h12345678);
      chk("s_mem_be", 64'(bus.mem_be), 64'h3);
      cyc();
    end
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0;
    exp_q.push_back('{ls: 1'b1, data: 32'h0});
    @(negedge clk);
    chk("s_mem_req_resp", 64'(bus.mem_req), 64'd0);
    chk("s_ls_rvalid", 64'(bus.ls_rvalid), 64'd1);
    cyc();
    bus.mem_rvalid = 1'b0;

    // A stray mem_rvalid while IDLE must be ignored.
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD;
    @(negedge clk);
    chk("stray_if_rvalid", 64'(bus.if_rvalid), 64'd0);
    chk("stray_ls_rvalid", 64'(bus.ls_rvalid), 64'd0);
    cyc();
    bus.mem_rvalid = 1'b0;

    // A mem_rvalid that arrives together with mem_gnt in ISSUE must be ignored.
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    @(negedge clk);
    chk("g_if_gnt", 64'(bus.if_gnt), 64'd1);
    cyc();
    bus.if_req = 1'b0; bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD1;
    @(negedge clk);
    chk("g_if_rvalid_issue", 64'(bus.if_rvalid), 64'd0);
    chk("g_mem_req", 64'(bus.mem_req), 64'd1);
    cyc();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("g_busy_resp", 64'(busy), 64'd1);
    chk("g_mem_req_resp", 64'(bus.mem_req), 64'd0);
    cyc();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
    exp_q.push_back('{ls: 1'b0, data: 32'hCAFEF00D});
    @(negedge clk);
    chk("g_if_rvalid", 64'(bus.if_rvalid), 64'd1);
    cyc();
    bus.mem_rvalid = 1'b0;

    // Reset in RESP aborts the transaction. The late response is dropped.
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h44;
    @(negedge clk);
    chk("r_ls_gnt", 64'(bus.ls_gnt), 64'd1);
    cyc();
    bus.ls_req = 1'b0; bus.mem_gnt = 1'b1;
    cyc();
    bus.mem_gnt = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("r_busy_resp", 64'(busy), 64'd1);
    cyc();
    rst = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55;
    @(negedge clk);
    chk("r_ls_rvalid", 64'(bus.ls_rvalid), 64'd0);
    chk("r_if_rvalid", 64'(bus.if_rvalid), 64'd0);
    chk("r_busy", 64'(busy), 64'd0);
    chk("r_mem_req", 64'(bus.mem_req), 64'd0);
    chk("r_mem_addr", 64'(bus.mem_addr), 64'd0);
    cyc();
    bus.mem_rvalid = 1'b0;

    // Both requesters active continuously after a fresh reset.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h500;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h400;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_ls = (k % 2 == 0);
`else
      exp_ls = 1'b1;
`endif
      @(negedge clk);
      chk("t_ls_gnt", 64'(bus.ls_gnt), 64'(exp_ls));
      chk("t_if_gnt", 64'(bus.if_gnt), 64'(!exp_ls));
      cyc();
      bus.mem_gnt = 1'b1;
      @(negedge clk);
      chk("t_mem_addr", 64'(bus.mem_addr), exp_ls ? 64'h400 : 64'h500);
      chk("t_mem_we", 64'(bus.mem_we), 64'd0);
      cyc();
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hA0 + k;
      exp_q.push_back('{ls: exp_ls, data: 32'hA0 + k});
      @(negedge clk);
      chk("t_rvalid", 64'(exp_ls ? bus.ls_rvalid : bus.if_rvalid), 64'd1);
      cyc();
      bus.mem_rvalid = 1'b0;
    end
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    cyc();
    cyc();

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, sets the address width of all address ports.
REQ-002 Parameter DATA_W, default 32, sets the data width; byte-enable width SHALL be DATA_W/8.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 if_req  input  1  fetch read request; held with if_addr stable until if_gnt.
REQ-006 if_addr  input  ADDR_W  fetch address.
REQ-007 if_gnt  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid  output  1  fetch read data valid this cycle.
REQ-009 ls_req  input  1  load/store request; held with ls_we, ls_addr, ls_wdata and ls_be stable until ls_gnt.
REQ-010 ls_we  input  1  1 = store, 0 = load.
REQ-011 ls_addr, ls_wdata  input  ADDR_W, DATA_W  load/store address and store data.
REQ-012 ls_be  input  DATA_W/8  store byte enables.
REQ-013 ls_gnt, ls_rvalid  output  1 each  load/store accepted; load/store response (load data or store ack).
REQ-014 rdata  output  DATA_W  response data shared by both requesters; valid only with if_rvalid or ls_rvalid.
REQ-015 mem_req, mem_we  output  1 each  memory request and its write flag.
REQ-016 mem_addr, mem_wdata, mem_be  output  ADDR_W, DATA_W, DATA_W/8  registered request fields.
REQ-017 mem_gnt  input  1  memory accepts mem_req this cycle.
REQ-018 mem_rvalid, mem_rdata  input  1, DATA_W  memory response and its data.
REQ-019 busy  output  1  high whenever state is not IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE and RESP, with at most one transaction outstanding.
REQ-021 In IDLE with any request, the block SHALL select one winner, assert that requester's gnt combinationally in the same cycle, latch the winner's fields and owner, and enter ISSUE.
REQ-022 When both requests are high in IDLE, the winner SHALL follow the arbitration policy defined under Configuration.
REQ-023 Fetch requests SHALL be issued with mem_we=0 and mem_be all-ones.
REQ-024 In ISSUE, mem_req SHALL be 1 with latched fields held stable; on mem_gnt the FSM SHALL enter RESP and drop mem_req the next cycle.
REQ-025 In RESP, on mem_rvalid the block SHALL pass mem_rdata to rdata and assert the owner's rvalid in the same cycle (zero added latency), then return to IDLE.
REQ-026 mem_rvalid outside RESP SHALL be ignored and SHALL NOT produce any rvalid.
REQ-027 No gnt SHALL be asserted outside IDLE, and if_gnt and ls_gnt SHALL never be high together.
REQ-028 Minimum latency SHALL be gnt in cycle 0, mem_req in cycle 1, and rvalid in cycle 2 when mem_gnt arrives in cycle 1 and mem_rvalid in cycle 2.
REQ-029 A new request SHALL be granted no earlier than the cycle after rvalid.
REQ-030 If mem_gnt and mem_rvalid are high in the same ISSUE cycle, mem_rvalid SHALL be ignored.

Reset
REQ-031 On rst, the state SHALL be IDLE and mem_req, mem_we, busy, both gnts and both rvalids SHALL be 0.
REQ-032 On rst, mem_addr, mem_wdata, mem_be, rdata and the last-owner register SHALL be set to 0, where last-owner 0 means fetch.
REQ-033 rst asserted in ISSUE or RESP SHALL abort the transaction; the pending response SHALL be discarded per REQ-026.

Configuration
REQ-034 With ARB_ROUND_ROBIN_EN defined, a tie SHALL be granted to the requester that was not the last owner, and the last-owner register SHALL update on every grant.
REQ-035 Without ARB_ROUND_ROBIN_EN, ls SHALL always win a tie (fixed priority) and the last-owner register SHALL be absent.

Verification
REQ-036 Lone fetch, if_addr=0x100, mem_gnt in cycle 1, mem_rvalid with 0xDEADBEEF in cycle 2 -> if_gnt in cycle 0, mem_req in cycle 1 only, if_rvalid with rdata=0xDEADBEEF in cycle 2.
REQ-037 Store, ls_addr=0x2000, ls_wdata=0x12345678, ls_be=0011, mem_gnt stalled 3 cycles -> mem_req high 4 cycles, fields stable throughout, mem_we=1, then ls_rvalid on the ack.
REQ-038 Both requesting continuously after reset, with round-robin enabled -> grant order ls, if, ls, if; without the macro -> ls every time.
REQ-039 rst asserted in RESP, then mem_rvalid one cycle later -> no rvalid, state IDLE, mem_req=0.
REQ-040 Stray mem_rvalid while IDLE, and mem_rvalid together with mem_gnt in ISSUE -> no rvalid in either case.
